// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI command master: 10-bit command words to SS_n/MOSI frames, 8-bit MISO replies
// One MOSI bit per clk; read-data frames (opcode 11) append a turnaround and an 8-bit capture window.
module spi_cmd_master #(
  parameter int READ_TURNAROUND = 2,
  parameter int MIN_GAP         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TURN, CAPTURE, GAP} state_t;

  state_t     state_q, state_d;
  logic [9:0] sh_q;
  logic       rd_q;
  logic [3:0] cnt_q;
  logic [6:0] cap_q;
  logic       accept;

  assign accept = cmd_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = LEAD;
      LEAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd9) state_d = rd_q ? TURN : GAP;
      TURN:    if (cnt_q == 4'(READ_TURNAROUND - 1)) state_d = CAPTURE;
      CAPTURE: if (cnt_q == 4'd7) state_d = GAP;
      GAP:     if (cnt_q == 4'(MIN_GAP - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts cycles spent in the current state and restarts on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      sh_q      <= 10'd0;
      rd_q      <= 1'b0;
      cap_q     <= 7'd0;
      rsp_data  <= 8'h00;
      rsp_valid <= 1'b0;
    end else begin
      cnt_q     <= (state_d != state_q || state_q == IDLE) ? 4'd0 : cnt_q + 4'd1;
      rsp_valid <= 1'b0;
      if (accept) begin
        sh_q <= cmd_data;
        rd_q <= &cmd_data[9:8];
      end else if (state_q == SHIFT) begin
        sh_q <= {sh_q[8:0], 1'b0};
      end
      if (state_q == CAPTURE) begin
        cap_q <= {cap_q[5:0], MISO};
        if (cnt_q == 4'd7) begin
          rsp_data  <= {cap_q, MISO};
          rsp_valid <= 1'b1;
        end
      end
    end
  end

  // LEAD repeats the command MSB, so MOSI reads sh_q[9] without shifting in that cycle.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign SS_n      = (state_q == IDLE) || (state_q == GAP);
  assign MOSI      = ((state_q == LEAD) || (state_q == SHIFT)) ? sh_q[9] : 1'b0;

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb/tb_spi_cmd_master.sv - scoreboard bench for spi_cmd_master
// Frames and responses are queued at issue time and checked by a negedge monitor.
module tb_spi_cmd_master;

  localparam int RT   = 2;
  localparam int MG   = 1;
  localparam int RT_B = 3;
  localparam int MG_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
  logic [9:0] cmd_data;
  logic [7:0] rsp_data;
  logic       b_cmd_valid, b_cmd_ready, b_rsp_valid, b_busy, b_ss_n, b_mosi, b_miso;
  logic [9:0] b_cmd_data;
  logic [7:0] b_rsp_data;

  spi_cmd_master #(.READ_TURNAROUND(RT), .MIN_GAP(MG)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_cmd_master #(.READ_TURNAROUND(RT_B), .MIN_GAP(MG_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
    .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(b_miso)
  );

  typedef struct {
    logic [10:0] bits;
    int          len;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] miso_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: collects each SS_n-low frame, drives MISO in the capture window, checks responses and gaps.
  int          idx, gap, zero_err;
  bit          in_frame, last_rv;
  logic [10:0] got;
  logic [7:0]  cur_miso, e_m;
  frame_t      f_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; idx = 0; gap = 0; last_rv = 0; miso = 1'b1;
    end else begin
      if (rsp_valid) begin
        chk("rsp_pulse_width", int'(last_rv), 0);
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e_m = rsp_q.pop_front();
          chk("rsp_data", int'(rsp_data), int'(e_m));
        end
      end
      last_rv = rsp_valid;
      if (!ss_n) begin
        if (!in_frame) begin
          in_frame = 1; idx = 0; got = '0; zero_err = 0;
        end
        if (idx < 11) got = {got[9:0], mosi};
        else if (mosi) zero_err++;
        if (idx == 11 + RT) cur_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
        if (idx >= 11 + RT && idx < 19 + RT) miso = cur_miso[7 - (idx - 11 - RT)];
        else miso = 1'b1;
        idx++;
      end else begin
        miso = 1'b1;
        if (in_frame) begin
          in_frame = 0;
          if (frame_q.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            f_m = frame_q.pop_front();
            chk("frame_len", idx, f_m.len);
            chk("frame_mosi", int'(got), int'(f_m.bits));
            chk("frame_tail_mosi_zero", zero_err, 0);
          end
        end
        if (busy) gap++;
        else if (gap > 0) begin
          chk("gap_len", gap, MG);
          gap = 0;
        end
      end
    end
  end

  task automatic send(input logic [9:0] c, input bit expect_frame, output int acc);
    int     t;
    frame_t f;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = c;
    if (expect_frame) begin
      f.bits = {c[9], c};
      f.len  = (c[9:8] == 2'b11) ? 11 + RT + 8 : 11;
      frame_q.push_back(f);
    end
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", int'(t < 100), 1);
    @(posedge clk);
    acc = cyc;
  endtask

  task automatic rd(input logic [7:0] b, output int acc);
    miso_q.push_back(b);
    rsp_q.push_back(b);
    send(10'h300, 1'b1, acc);
  endtask

  task automatic finish_cmd();
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while ((busy || !ss_n) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", int'(t < 300), 1);
  endtask

  task automatic run_b(input logic [7:0] pat);
    int low, high, rv;
    logic [7:0] rdv;
    low = 0; high = 0; rv = 0; rdv = 8'h00;
    @(negedge clk);
    b_cmd_valid = 1'b1;
    b_cmd_data  = 10'h3FF;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (!b_ss_n) begin
        b_miso = (low >= 14 && low < 22) ? pat[21 - low] : 1'b1;
        low++;
      end else if (b_busy) begin
        high++;
      end
      if (b_rsp_valid) begin
        rv++;
        rdv = b_rsp_data;
      end
      if (low > 0 && !b_busy) break;
      @(negedge clk);
    end
    chk("b_frame_len", low, 11 + RT_B + 8);
    chk("b_gap_len", high, MG_B);
    chk("b_rsp_pulses", rv, 1);
    chk("b_rsp_data", int'(rdv), int'(pat));
  endtask

  int a1, a2, a3;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    b_cmd_valid = 1'b0; b_cmd_data = '0; b_miso = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ss_n", int'(ss_n), 1);
    chk("reset_mosi", int'(mosi), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    rst_n = 1'b1;

    send(10'h0A5, 1'b1, a1);
    finish_cmd();
    chk("ready_after_wr", int'(cmd_ready), 1);

    send(10'h010, 1'b1, a1);
    send(10'h13C, 1'b1, a1);
    send(10'h210, 1'b1, a1);
    rd(8'h3C, a1);
    finish_cmd();

    rd(8'hB2, a1);
    finish_cmd();
    chk("rsp_data_holds", int'(rsp_data), 8'hB2);

    send(10'h0F1, 1'b1, a1);
    send(10'h155, 1'b1, a2);
    send(10'h2AA, 1'b1, a3);
    finish_cmd();
    chk("accept_spacing_1", a2 - a1, 11 + MG + 1);
    chk("accept_spacing_2", a3 - a2, 11 + MG + 1);

    send(10'h15A, 1'b0, a1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_frame_ss_n", int'(ss_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ss_n", int'(ss_n), 1);
    chk("async_reset_mosi", int'(mosi), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_reset", int'(cmd_ready), 1);
    chk("no_rsp_after_reset", int'(rsp_valid), 0);
    send(10'h0C3, 1'b1, a1);
    finish_cmd();

    run_b(8'h5A);

    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("frame_queue_drained", frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- Upstream driver for the SPI slave + RAM wrapper. Converts 10-bit parallel command words into SPI frames on SS_n/MOSI.
- On read-data commands, captures the 8-bit MISO reply and returns it as a parallel response.
- Runs on the same clk as the slave; no separate SCK. One MOSI bit per clk cycle.
- Serves as the stimulus front end of the wrapper system and the host-side block for integration.

Parameters:
- READ_TURNAROUND, 2, clk cycles between the last command bit and the first MISO capture on read-data frames (range 1-7).
- MIN_GAP, 1, minimum clk cycles SS_n stays high between frames (range 1-15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command word present.
- cmd_ready  out  1  master can accept a command this cycle.
- cmd_data  in  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rsp_valid  out  1  one-cycle pulse, rsp_data valid.
- rsp_data  out  8  byte captured from MISO on a read-data frame.
- busy  out  1  frame in progress (SS_n low or gap active).
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00, FSM=IDLE, counters=0.
- Reset asserted mid-frame: SS_n=1 immediately (async); partial frame discarded; no rsp_valid.
- Handshake:
  - Command accepted on a posedge with cmd_valid && cmd_ready; cmd_data latched into a shift register.
  - cmd_ready=1 only in IDLE. cmd_valid while not ready is ignored; no queueing.
- FSM states: IDLE, LEAD, SHIFT, TURN, CAPTURE, GAP.
- IDLE: SS_n=1, MOSI=0. On accept, go to LEAD.
- LEAD (1 cycle): SS_n=0, MOSI=cmd_data[9] (0 for write frames, 1 for read frames). Go to SHIFT.
- SHIFT (10 cycles): MOSI=cmd_data[9] down to cmd_data[0], MSB first.
  - After the bit-0 cycle: opcode 11 goes to TURN; all others go to GAP.
- TURN (READ_TURNAROUND cycles): SS_n=0, MOSI=0, no capture.
- CAPTURE (8 cycles): SS_n=0, MOSI=0. MISO sampled at each posedge into rsp_data shift, MSB first.
  - On the 8th sample: rsp_data is updated and rsp_valid=1 for exactly the next cycle. Go to GAP.
- GAP (MIN_GAP cycles): SS_n=1, MOSI=0, busy=1. Then go to IDLE.
- busy = (state != IDLE).
- Frame lengths (SS_n low):
  - 11 cycles for opcodes 00/01/10.
  - 11+READ_TURNAROUND+8 cycles for opcode 11 (21 at default).
- Minimum accept-to-accept spacing = SS_n-low length + MIN_GAP + 1.
- rsp_data holds its last value until the next read-data frame completes; rsp_valid is never asserted on non-read frames.
- No MISO sampling outside CAPTURE; MISO X/Z outside CAPTURE must not affect any output.

Test Plan:
- Reset then cmd_data=10'h0A5 (wr-addr 0xA5) -> SS_n low 11 cycles.
  - MOSI = 0,0,0,1,0,1,0,0,1,0,1.
  - Then SS_n high ≥1 cycle; no rsp_valid; cmd_ready returns to 1.
- Against the golden wrapper, send in sequence: wr-addr 0x10, wr-data 0x3C, rd-addr 0x10, rd-data 0x00.
  - Expected: rsp_valid pulses once with rsp_data=8'h3C. The rd-data frame holds SS_n low 21 cycles.
- MISO forced to pattern 1,0,1,1,0,0,1,0 during CAPTURE of an rd-data frame -> rsp_data=8'hB2 with a one-cycle rsp_valid.
- cmd_valid held high with 3 distinct commands -> each frame is separated by exactly MIN_GAP SS_n-high cycles.
  - cmd_valid during busy is not accepted; commands are issued in order.
- rst_n asserted during SHIFT bit 4 -> SS_n=1 and MOSI=0 without waiting for clk; cmd_ready=1 after release.
  - Next command produces a clean full frame.
- READ_TURNAROUND=3, MIN_GAP=4 -> rd-data frame has SS_n low 22 cycles and SS_n high for 4 cycles after; the capture window shifts by one cycle.
